// File: rtl/line_collector.sv
// Gathers a serial bit stream into line words and queues completed lines in a
// first-word-fall-through FIFO with a valid/ready output port.
module line_collector #(
  parameter int unsigned LINE_W = 16,
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LVL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pin,
  input  logic              co,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_split,
  output logic [LVL_W-1:0]  level,
  output logic              ovf
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LINE_W-1:0] acc;
  logic [LEN_W-1:0]  cnt;
  logic [PTR_W-1:0]  rptr, wptr;

  logic [LINE_W-1:0] mem_data  [DEPTH];
  logic [LEN_W-1:0]  mem_len   [DEPTH];
  logic              mem_split [DEPTH];

  logic              end_mark, at_max, term, line_split;
  logic [LINE_W-1:0] line_data;
  logic [LEN_W-1:0]  line_len;
  logic              pop, push, drop, head_from_push;
  logic [LVL_W-1:0]  level_nxt;
  logic [PTR_W-1:0]  rptr_nxt;

  // Line termination, push/pop decisions and next FIFO state
  always_comb begin
    end_mark       = en & (co | flush);
    at_max         = (cnt == LEN_W'(LINE_W - 1));
    term           = end_mark | (en & at_max) | (flush & ~en & (cnt != '0));
    line_split     = en & ~end_mark & at_max;
    line_data      = en ? {acc[LINE_W-2:0], pin} : acc;
    line_len       = cnt + LEN_W'(en);
    pop            = out_valid & out_ready;
    push           = term & ((level != LVL_W'(DEPTH)) | pop);
    drop           = term & ~push;
    level_nxt      = level + LVL_W'(push) - LVL_W'(pop);
    rptr_nxt       = rptr + PTR_W'(pop);
    // The slot being written becomes the head when nothing else remains queued
    head_from_push = push & (level == LVL_W'(pop));
  end

  // Accumulator, pointers, flags and registered head of the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      rptr      <= '0;
      wptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_split <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (term) begin
        acc <= '0;
        cnt <= '0;
      end else if (en) begin
        acc <= line_data;
        cnt <= line_len;
      end
      if (push) wptr <= wptr + PTR_W'(1);
      if (drop) ovf <= 1'b1;
      rptr      <= rptr_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (level_nxt == '0) begin
        out_data  <= '0;
        out_len   <= '0;
        out_split <= 1'b0;
      end else if (head_from_push) begin
        out_data  <= line_data;
        out_len   <= line_len;
        out_split <= line_split;
      end else begin
        out_data  <= mem_data[rptr_nxt];
        out_len   <= mem_len[rptr_nxt];
        out_split <= mem_split[rptr_nxt];
      end
    end
  end

  // FIFO storage needs no reset; occupancy tracking guards every read
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_data[wptr]  <= line_data;
      mem_len[wptr]   <= line_len;
      mem_split[wptr] <= line_split;
    end
  end

endmodule

// File: tb/tb_line_collector.sv
// Self-checking bench for line_collector: directed vector table, hand-written
// corner sequences and randomized traffic against a line-level queue model.
module tb_line_collector;

  localparam int unsigned LINE_W = 16;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LVL_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0, pin = 1'b0, co = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic              out_valid, out_split, ovf;
  logic [LINE_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic [LVL_W-1:0]  level;

  int checks = 0;
  int failures = 0;

  line_collector #(.LINE_W(LINE_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pin(pin), .co(co), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_split(out_split), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: whole lines in a queue, current partial line as value+length
  typedef struct {
    int unsigned data;
    int unsigned len;
    bit          split;
  } line_t;

  line_t       q[$];
  int unsigned cur_data = 0;
  int unsigned cur_len = 0;
  bit          m_ovf = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit p, input bit c,
                              input bit f, input bit rdy);
    bit    popped, was_full, ends;
    line_t ln;
    if (r) begin
      q.delete();
      cur_data = 0;
      cur_len = 0;
      m_ovf = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    popped   = (q.size() != 0) && rdy;
    ends = 0;
    ln.split = 0;
    if (e) begin
      cur_data = cur_data * 2 + p;
      cur_len++;
      if (c || f) ends = 1;
      else if (cur_len == LINE_W) begin
        ends = 1;
        ln.split = 1;
      end
    end else if (f && cur_len > 0) begin
      ends = 1;
    end
    if (popped) void'(q.pop_front());
    if (ends) begin
      ln.data = cur_data;
      ln.len  = cur_len;
      if (!was_full || popped) q.push_back(ln);
      else m_ovf = 1;
      cur_data = 0;
      cur_len = 0;
    end
  endtask

  task automatic compare_model();
    bit have;
    have = (q.size() != 0);
    check("m_valid", 32'(out_valid), 32'(have));
    check("m_data",  32'(out_data),  have ? q[0].data : 0);
    check("m_len",   32'(out_len),   have ? q[0].len : 0);
    check("m_split", 32'(out_split), have ? 32'(q[0].split) : 0);
    check("m_level", 32'(level),     q.size());
    check("m_ovf",   32'(ovf),       32'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model, sample outputs after the edge
  task automatic step(input bit r, input bit e, input bit p, input bit c,
                      input bit f, input bit rdy);
    rst = r; en = e; pin = p; co = c; flush = f; out_ready = rdy;
    @(posedge clk);
    model_update(r, e, p, c, f, rdy);
    #1;
    compare_model();
  endtask

  task automatic expect_head(input string tag, input bit v, input int unsigned d,
                             input int unsigned l, input bit s, input int unsigned lv,
                             input bit o);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  d);
    check({tag, "_len"},   32'(out_len),   l);
    check({tag, "_split"}, 32'(out_split), 32'(s));
    check({tag, "_level"}, 32'(level),     lv);
    check({tag, "_ovf"},   32'(ovf),       32'(o));
  endtask

  typedef struct {
    bit          e, p, c, f, rdy;
    bit          v;
    int unsigned d, l;
    bit          s;
    int unsigned lv;
    bit          o;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // single line 1,0,1,1 ; pop ; flush after 1,1,0 ; flush and co no-ops
    vecs[0]  = '{1,1,0,0,0, 0,0,0,0,0,0};
    vecs[1]  = '{1,0,0,0,0, 0,0,0,0,0,0};
    vecs[2]  = '{1,1,0,0,0, 0,0,0,0,0,0};
    vecs[3]  = '{1,1,1,0,0, 1,'hB,4,0,1,0};
    vecs[4]  = '{0,0,0,0,1, 0,0,0,0,0,0};
    vecs[5]  = '{1,1,0,0,0, 0,0,0,0,0,0};
    vecs[6]  = '{1,1,0,0,0, 0,0,0,0,0,0};
    vecs[7]  = '{1,0,0,0,0, 0,0,0,0,0,0};
    vecs[8]  = '{0,0,0,1,0, 1,'h6,3,0,1,0};
    vecs[9]  = '{0,0,0,1,1, 0,0,0,0,0,0};
    vecs[10] = '{0,0,0,1,0, 0,0,0,0,0,0};
    vecs[11] = '{0,0,1,0,0, 0,0,0,0,0,0};

    #2;
    step(1, 0, 0, 0, 0, 0);
    expect_head("rst", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(0, vecs[i].e, vecs[i].p, vecs[i].c, vecs[i].f, vecs[i].rdy);
      expect_head($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].l,
                  vecs[i].s, vecs[i].lv, vecs[i].o);
    end

    // split at LINE_W: 20 alternating bits starting at 1, co on the last
    for (int i = 0; i < 20; i++) begin
      step(0, 1, (i % 2 == 0), (i == 19), 0, 0);
      if (i == 15) expect_head("split1", 1, 'hAAAA, 16, 1, 1, 0);
    end
    check("split_lvl", 32'(level), 2);
    step(0, 0, 0, 0, 0, 1);
    expect_head("split2", 1, 'hA, 4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    expect_head("split_empty", 0, 0, 0, 0, 0, 0);

    // back-to-back 1-bit lines keep every bit
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    expect_head("b2b", 1, 1, 1, 0, 3, 0);
    step(0, 0, 0, 0, 0, 1);
    expect_head("b2b_2", 1, 0, 1, 0, 2, 0);

    // overflow: DEPTH+1 lines with no consumer
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) step(0, 1, (i % 2 == 0), 1, 0, 0);
    check("ovf_level", 32'(level), DEPTH);
    check("ovf_flag", 32'(ovf), 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_head%0d", i), 32'(out_data), (i % 2 == 0) ? 1 : 0);
      step(0, 0, 0, 0, 0, 1);
    end
    expect_head("ovf_drained", 0, 0, 0, 0, 0, 1);

    // full FIFO with same-cycle pop accepts the push
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, (i % 2 == 1), 1, 0, 0);
    step(0, 1, 1, 1, 0, 1);
    expect_head("fullpop", 1, 1, 1, 0, DEPTH, 0);

    // reset mid-line with two lines queued
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1);
    expect_head("midrst", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    expect_head("postrst", 1, 1, 2, 0, 1, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 19) < 3),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
